// File: rtl/exa_crosb_input_arbiter_vc.sv
// Per-input VC arbiter upstream of the crossbar output arbiters: builds per-output requests,
// accepts one grant, then streams the chosen queue until its last flit.
// Build option: define EXA_INARB_OUTPUT_RR_EN for round-robin selection among granting outputs.
module exa_crosb_input_arbiter_vc #(
  parameter int prio_num   = 2,
  parameter int vc_num     = 2,
  parameter int output_num = 4,
  parameter int logOutput  = $clog2(output_num),
  parameter int logVcPrio  = $clog2(prio_num * vc_num)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [prio_num*vc_num-1:0] i_valid,
  input  logic [logOutput-1:0]       i_dest [prio_num*vc_num],
  input  logic [prio_num*vc_num-1:0] i_head_last,
  input  logic                       i_ready,
  input  logic [output_num-1:0]      i_grant,
  input  logic [output_num-1:0]      i_out_cts,
  output logic [prio_num*vc_num-1:0] o_request [output_num],
  output logic [output_num-1:0]      o_cts,
  output logic [output_num-1:0]      o_last,
  output logic [prio_num*vc_num-1:0] o_pop,
  output logic                       o_valid,
  output logic [logVcPrio-1:0]       o_queue_sel,
  output logic [logOutput-1:0]       o_output_sel
);
  localparam int num_q    = prio_num * vc_num;
  localparam int log_prio = (prio_num > 1) ? $clog2(prio_num) : 1;
  localparam int log_vc   = (vc_num > 1) ? $clog2(vc_num) : 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] XFER = 2'b01;

  logic [1:0]           state;
  logic [logOutput-1:0] k_sel;
  logic [logVcPrio-1:0] q_sel;
  logic [log_prio-1:0]  p_sel;
  logic [log_vc-1:0]    v_sel;
  logic [log_vc-1:0]    vc_ptr [prio_num];

  logic [num_q-1:0]      req [output_num];
  logic [output_num-1:0] eligible;
  logic                  out_found;
  logic [logOutput-1:0]  out_pick;
  logic [num_q-1:0]      req_pick;
  logic                  q_found;
  logic [log_prio-1:0]   p_pick;
  logic [log_vc-1:0]     v_pick;
  logic [logVcPrio-1:0]  q_pick;
  logic                  xfer;
  logic                  pop;

  assign xfer = (state == XFER);
  assign pop  = xfer & i_valid[q_sel] & i_ready;

  // Requests are masked during reset so every output reads 0 while resetn is low.
  always_comb begin
    for (int k = 0; k < output_num; k++) begin
      req[k] = '0;
      for (int q = 0; q < num_q; q++) begin
        req[k][q] = resetn & (state == IDLE) & i_valid[q] & (int'(i_dest[q]) == k);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < output_num; k++) begin
      o_request[k] = req[k];
      eligible[k]  = i_grant[k] & i_out_cts[k] & (|req[k]);
    end
  end

`ifdef EXA_INARB_OUTPUT_RR_EN
  logic [logOutput-1:0] out_ptr;

  always_comb begin
    out_found = 1'b0;
    out_pick  = '0;
    for (int i = 0; i < output_num; i++) begin
      if (!out_found && eligible[logOutput'((int'(out_ptr) + i) % output_num)]) begin
        out_found = 1'b1;
        out_pick  = logOutput'((int'(out_ptr) + i) % output_num);
      end
    end
  end
`else
  always_comb begin
    out_found = 1'b0;
    out_pick  = '0;
    for (int i = 0; i < output_num; i++) begin
      if (!out_found && eligible[i]) begin
        out_found = 1'b1;
        out_pick  = logOutput'(i);
      end
    end
  end
`endif

  // Highest priority first; inside a priority, rotate over VCs from that priority's pointer.
  always_comb begin
    q_found  = 1'b0;
    p_pick   = '0;
    v_pick   = '0;
    q_pick   = '0;
    req_pick = req[out_pick];
    for (int p = prio_num - 1; p >= 0; p--) begin
      for (int i = 0; i < vc_num; i++) begin
        if (!q_found &&
            req_pick[logVcPrio'(p * vc_num + (int'(vc_ptr[p]) + i) % vc_num)]) begin
          q_found = 1'b1;
          p_pick  = log_prio'(p);
          v_pick  = log_vc'((int'(vc_ptr[p]) + i) % vc_num);
          q_pick  = logVcPrio'(p * vc_num + (int'(vc_ptr[p]) + i) % vc_num);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      k_sel <= '0;
      q_sel <= '0;
      p_sel <= '0;
      v_sel <= '0;
      for (int p = 0; p < prio_num; p++) begin
        vc_ptr[p] <= '0;
      end
`ifdef EXA_INARB_OUTPUT_RR_EN
      out_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (out_found && q_found) begin
            state <= XFER;
            k_sel <= out_pick;
            q_sel <= q_pick;
            p_sel <= p_pick;
            v_sel <= v_pick;
`ifdef EXA_INARB_OUTPUT_RR_EN
            out_ptr <= logOutput'((int'(out_pick) + 1) % output_num);
`endif
          end
        end
        XFER: begin
          // Only the last flit releases the output; empty heads and back-pressure just wait.
          if (pop && i_head_last[q_sel]) begin
            vc_ptr[p_sel] <= log_vc'((int'(v_sel) + 1) % vc_num);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_cts  = '0;
    o_last = '0;
    o_pop  = '0;
    if (xfer) begin
      o_cts[k_sel] = 1'b1;
    end
    if (pop) begin
      o_pop[q_sel] = 1'b1;
      if (i_head_last[q_sel]) begin
        o_last[k_sel] = 1'b1;
      end
    end
  end

  assign o_valid      = xfer & i_valid[q_sel];
  assign o_queue_sel  = xfer ? q_sel : '0;
  assign o_output_sel = xfer ? k_sel : '0;

endmodule

// File: tb/tb_exa_crosb_input_arbiter_vc.sv
// Directed bench for exa_crosb_input_arbiter_vc; expected transfer cycles are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_exa_crosb_input_arbiter_vc;
  localparam int NQ = 4;
  localparam int NO = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [NQ-1:0] i_valid;
  logic [1:0]    i_dest [NQ];
  logic [NQ-1:0] i_head_last;
  logic          i_ready;
  logic [NO-1:0] i_grant;
  logic [NO-1:0] i_out_cts;
  logic [NQ-1:0] o_request [NO];
  logic [NO-1:0] o_cts;
  logic [NO-1:0] o_last;
  logic [NQ-1:0] o_pop;
  logic          o_valid;
  logic [1:0]    o_queue_sel;
  logic [1:0]    o_output_sel;

  exa_crosb_input_arbiter_vc #(
    .prio_num(2), .vc_num(2), .output_num(4)
  ) dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_dest(i_dest),
    .i_head_last(i_head_last), .i_ready(i_ready), .i_grant(i_grant),
    .i_out_cts(i_out_cts), .o_request(o_request), .o_cts(o_cts), .o_last(o_last),
    .o_pop(o_pop), .o_valid(o_valid), .o_queue_sel(o_queue_sel),
    .o_output_sel(o_output_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] cts;
    logic [3:0] pop;
    logic [3:0] last;
    logic       valid;
    logic [1:0] qsel;
    logic [1:0] osel;
  } obs_t;

  obs_t          exp_q [$];
  int            n_chk = 0;
  int            n_fail = 0;
  int            rem [NQ];
  logic [NQ-1:0] sf;
  logic [NQ-1:0] hold;
  int            t3_order [4] = '{2, 3, 2, 3};
  logic [3:0]    t3_mask [4] = '{4'b1100, 4'b1100, 4'b1100, 4'b1000};

  function automatic obs_t mk(int k, int q, bit p, bit l, bit v);
    obs_t o;
    o.cts   = 4'(1 << k);
    o.pop   = p ? 4'(1 << q) : 4'b0;
    o.last  = l ? 4'(1 << k) : 4'b0;
    o.valid = v;
    o.qsel  = 2'(q);
    o.osel  = 2'(k);
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int q = 0; q < NQ; q++) begin
      i_valid[q]     = (rem[q] > 0) && !hold[q];
      i_head_last[q] = (rem[q] > 0) && (sf[q] || rem[q] == 1);
    end
  endtask

  // Advance one clock; the upstream source model retires flits the DUT popped.
  task automatic cycle();
    logic [NQ-1:0] p;
    #1;
    p = o_pop;
    @(posedge clk);
    #1;
    for (int q = 0; q < NQ; q++) begin
      if (p[q] && rem[q] > 0) rem[q]--;
    end
    drive();
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          obs_t a;
          obs_t e;
          @(negedge clk);
          if (o_cts != 0 || o_pop != 0 || o_last != 0 || o_valid) begin
            a = '{cts: o_cts, pop: o_pop, last: o_last, valid: o_valid,
                  qsel: o_queue_sel, osel: o_output_sel};
            n_chk++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL xfer_unexpected: got cts=%b pop=%b last=%b valid=%b q=%0d k=%0d, expected no transfer",
                       a.cts, a.pop, a.last, a.valid, a.qsel, a.osel);
            end else begin
              e = exp_q.pop_front();
              if (a !== e) begin
                n_fail++;
                $display("FAIL xfer_cycle: got cts=%b pop=%b last=%b valid=%b q=%0d k=%0d, expected cts=%b pop=%b last=%b valid=%b q=%0d k=%0d",
                         a.cts, a.pop, a.last, a.valid, a.qsel, a.osel,
                         e.cts, e.pop, e.last, e.valid, e.qsel, e.osel);
              end
            end
          end
        end
      end
      begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
      end
    join_none

    i_ready = 1'b1; i_grant = '0; i_out_cts = '1; sf = '0; hold = '0;
    for (int q = 0; q < NQ; q++) begin
      rem[q] = 0;
      i_dest[q] = '0;
    end
    drive();

    // Reset with a head flit present: everything must read 0.
    rem[2] = 1; sf[2] = 1'b1; i_dest[2] = 2'd1; drive();
    repeat (3) cycle();
    #2;
    chk("rst_cts", 32'(o_cts), 0);
    chk("rst_pop", 32'(o_pop), 0);
    chk("rst_last", 32'(o_last), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_sel", 32'({o_queue_sel, o_output_sel}), 0);
    chk("rst_req1", 32'(o_request[1]), 0);

    // Single-flit packet q2 -> output 1.
    resetn = 1'b1; i_grant = 4'b0010;
    #1;
    chk("t1_req1", 32'(o_request[1]), 32'h4);
    chk("t1_req0", 32'(o_request[0]), 0);
    exp_q.push_back(mk(1, 2, 1, 1, 1));
    cycle(); i_grant = '0;
    #2;
    chk("t1_xfer_req1", 32'(o_request[1]), 0);
    cycle();
    #2;
    chk("t1_idle_cts", 32'(o_cts), 0);

    // Priority: q3 (prio1) beats q0 (prio0) on output 2.
    sf = '0;
    rem[0] = 2; i_dest[0] = 2'd2; rem[3] = 3; i_dest[3] = 2'd2; drive();
    i_grant = 4'b0100;
    #1;
    chk("t2_req2", 32'(o_request[2]), 32'h9);
    exp_q.push_back(mk(2, 3, 1, 0, 1));
    exp_q.push_back(mk(2, 3, 1, 0, 1));
    exp_q.push_back(mk(2, 3, 1, 1, 1));
    cycle(); i_grant = '0;
    repeat (3) cycle();
    #1;
    chk("t2_req2_rest", 32'(o_request[2]), 32'h1);
    i_grant = 4'b0100;
    exp_q.push_back(mk(2, 0, 1, 0, 1));
    exp_q.push_back(mk(2, 0, 1, 1, 1));
    cycle(); i_grant = '0;
    repeat (2) cycle();

    // VC fairness within prio1: order 2,3,2,3.
    sf = 4'b1100; rem[2] = 2; rem[3] = 2; i_dest[2] = 2'd0; i_dest[3] = 2'd0; drive();
    for (int i = 0; i < 4; i++) begin
      i_grant = 4'b0001;
      #1;
      chk($sformatf("t3_req0_%0d", i), 32'(o_request[0]), 32'(t3_mask[i]));
      exp_q.push_back(mk(0, t3_order[i], 1, 1, 1));
      cycle(); i_grant = '0;
      cycle();
    end

    // Dual grant from outputs 0 and 3, starting from reset pointers.
    resetn = 1'b0; cycle(); resetn = 1'b1;
    sf = 4'b0011; rem[0] = 1; i_dest[0] = 2'd0; rem[1] = 1; i_dest[1] = 2'd3; drive();
    i_grant = 4'b1001;
    #1;
    chk("t4_req0", 32'(o_request[0]), 32'h1);
    chk("t4_req3", 32'(o_request[3]), 32'h2);
    exp_q.push_back(mk(0, 0, 1, 1, 1));
    cycle(); i_grant = '0;
    cycle();
    rem[0] = 1; drive(); i_grant = 4'b1001;
`ifdef EXA_INARB_OUTPUT_RR_EN
    exp_q.push_back(mk(3, 1, 1, 1, 1));
`else
    exp_q.push_back(mk(0, 0, 1, 1, 1));
`endif
    cycle(); i_grant = '0;
    cycle();
    for (int q = 0; q < NQ; q++) rem[q] = 0;
    drive(); resetn = 1'b0; cycle(); resetn = 1'b1;

    // Back-pressure: 3-flit packet, i_ready low 2 cycles after flit 1.
    sf = '0; rem[1] = 3; i_dest[1] = 2'd1; drive(); i_grant = 4'b0010;
    exp_q.push_back(mk(1, 1, 1, 0, 1));
    exp_q.push_back(mk(1, 1, 0, 0, 1));
    exp_q.push_back(mk(1, 1, 0, 0, 1));
    exp_q.push_back(mk(1, 1, 1, 0, 1));
    exp_q.push_back(mk(1, 1, 1, 1, 1));
    cycle(); i_grant = '0;
    cycle(); i_ready = 1'b0;
    cycle();
    cycle(); i_ready = 1'b1;
    cycle();
    cycle();
    #1;
    chk("t5_cts_after", 32'(o_cts), 0);

    // Empty head mid-packet: CTS held, no valid, packet resumes.
    rem[1] = 2; drive(); i_grant = 4'b0010;
    exp_q.push_back(mk(1, 1, 1, 0, 1));
    exp_q.push_back(mk(1, 1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 1, 1));
    cycle(); i_grant = '0;
    cycle(); hold[1] = 1'b1; drive();
    cycle(); hold[1] = 1'b0; drive();
    cycle();

    // Stale grants (no requester / CTS low) ignored; grant during XFER ignored.
    sf = 4'b0001; rem[0] = 1; i_dest[0] = 2'd2; drive();
    i_out_cts = 4'b1011; i_grant = 4'b0101;
    #1;
    chk("t6_req2", 32'(o_request[2]), 32'h1);
    cycle(); i_grant = '0; i_out_cts = '1;
    #1;
    chk("t6_stale_cts", 32'(o_cts), 0);
    sf = '0; rem[0] = 2; drive(); i_grant = 4'b0100;
    exp_q.push_back(mk(2, 0, 1, 0, 1));
    exp_q.push_back(mk(2, 0, 1, 1, 1));
    cycle(); i_grant = 4'b0111;
    #1;
    chk("t6_xfer_req2", 32'(o_request[2]), 0);
    cycle(); i_grant = '0;
    cycle();
    #1;
    chk("t6_idle_cts", 32'(o_cts), 0);

    // Reset mid-packet; VC pointer of prio1 must return to 0.
    sf = 4'b0100; rem[2] = 1; i_dest[2] = 2'd0; drive(); i_grant = 4'b0001;
    exp_q.push_back(mk(0, 2, 1, 1, 1));
    cycle(); i_grant = '0;
    cycle();
    sf = '0; rem[3] = 3; i_dest[3] = 2'd3; drive(); i_grant = 4'b1000;
    exp_q.push_back(mk(3, 3, 1, 0, 1));
    cycle(); i_grant = '0;
    cycle(); resetn = 1'b0;
    exp_q.push_back(mk(3, 3, 1, 0, 1));
    cycle();
    #1;
    chk("t7_rst_cts", 32'(o_cts), 0);
    chk("t7_rst_pop", 32'(o_pop), 0);
    chk("t7_rst_valid", 32'(o_valid), 0);
    chk("t7_rst_sel", 32'({o_queue_sel, o_output_sel}), 0);
    chk("t7_rst_req3", 32'(o_request[3]), 0);
    sf = 4'b1100; rem[2] = 1; rem[3] = 1; i_dest[3] = 2'd0; drive();
    resetn = 1'b1; i_grant = 4'b0001;
    #1;
    chk("t7_req0", 32'(o_request[0]), 32'hC);
    exp_q.push_back(mk(0, 2, 1, 1, 1));
    cycle(); i_grant = '0;
    cycle();
    for (int q = 0; q < NQ; q++) rem[q] = 0;
    drive();
    repeat (2) cycle();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
